// File: rtl/hazard_scoreboard_unit.sv
// EX-stage hazard/forwarding unit: tracks in-flight writers in a short record
// pipeline and produces bypass selects, hazard stalls and a stall-cycle count.
module hazard_scoreboard_unit #(
  parameter int AW         = 2,
  parameter int FWD_STAGES = 2,
  parameter int SP_REG     = 3,
  parameter int SP_LAT     = 2,
  parameter int CNT_W      = 3,
  parameter int SEL_W      = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic             flush,
  input  logic [AW-1:0]    ra_ex,
  input  logic [AW-1:0]    rb_ex,
  input  logic             use_a,
  input  logic             use_b,
  input  logic             we_ex,
  input  logic [AW-1:0]    dest_ex,
  input  logic [1:0]       kind_ex,
  input  logic             sp_wr_ex,
  input  logic             mc_start_ex,
  input  logic [CNT_W-1:0] mc_lat_ex,
  output logic             stall,
  output logic [SEL_W-1:0] fwd_a_sel,
  output logic             fwd_a_in,
  output logic [SEL_W-1:0] fwd_b_sel,
  output logic             fwd_b_in,
  output logic             mc_busy,
  output logic [15:0]      stall_cycles
);

  localparam logic [1:0] KIND_LOAD  = 2'd1;
  localparam logic [1:0] KIND_INPUT = 2'd2;

  typedef struct packed {
    logic             luse;
    logic [SEL_W-1:0] sel;
    logic             in_sel;
  } src_res_t;

  logic [FWD_STAGES:1] rec_vld_q, rec_vld_d;
  logic [FWD_STAGES:1] rec_we_q, rec_we_d;
  logic [AW-1:0]       rec_dest_q [1:FWD_STAGES];
  logic [AW-1:0]       rec_dest_d [1:FWD_STAGES];
  logic [1:0]          rec_kind_q [1:FWD_STAGES];
  logic [1:0]          rec_kind_d [1:FWD_STAGES];
  logic [2:0]          sp_pend_q, sp_pend_d;
  logic [CNT_W-1:0]    mc_cnt_q, mc_cnt_d;
  logic [15:0]         stall_cycles_q, stall_cycles_d;

  src_res_t res_a, res_b;
  logic     sp_hit, mc_busy_w, stall_w, go;

  // Youngest matching writer wins; a load/input result one stage out is not yet bypassable.
  function automatic src_res_t src_match(input logic [AW-1:0] addr, input logic active);
    src_res_t r;
    logic     found;
    r     = '0;
    found = 1'b0;
    if (active) begin
      for (int k = 1; k <= FWD_STAGES; k++) begin
        if (!found && rec_vld_q[k] && rec_we_q[k] && (rec_dest_q[k] == addr)) begin
          found = 1'b1;
          if ((rec_kind_q[k] == KIND_LOAD) || (rec_kind_q[k] == KIND_INPUT)) begin
            if (k == 1) begin
              r.luse = 1'b1;
            end else begin
              r.sel    = SEL_W'(k);
              r.in_sel = (rec_kind_q[k] == KIND_INPUT);
            end
          end else begin
            r.sel = SEL_W'(k);
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    res_a     = src_match(ra_ex, use_a & issue_valid);
    res_b     = src_match(rb_ex, use_b & issue_valid);
    sp_hit    = (sp_pend_q != 3'd0) && issue_valid &&
                ((use_a && (ra_ex == AW'(SP_REG))) || (use_b && (rb_ex == AW'(SP_REG))));
    mc_busy_w = (mc_cnt_q != '0);
    stall_w   = rst_n & ~flush & (res_a.luse | res_b.luse | sp_hit | (mc_busy_w & issue_valid));
    go        = issue_valid & ~stall_w & ~flush;

    stall        = stall_w;
    fwd_a_sel    = rst_n ? res_a.sel : '0;
    fwd_a_in     = rst_n & res_a.in_sel;
    fwd_b_sel    = rst_n ? res_b.sel : '0;
    fwd_b_in     = rst_n & res_b.in_sel;
    mc_busy      = rst_n & mc_busy_w;
    stall_cycles = stall_cycles_q;
  end

  always_comb begin
    rec_vld_d     = rec_vld_q;
    rec_we_d      = rec_we_q;
    rec_dest_d    = rec_dest_q;
    rec_kind_d    = rec_kind_q;
    rec_vld_d[1]  = go;
    rec_we_d[1]   = we_ex;
    rec_dest_d[1] = dest_ex;
    rec_kind_d[1] = kind_ex;
    for (int k = 2; k <= FWD_STAGES; k++) begin
      rec_vld_d[k]  = rec_vld_q[k-1];
      rec_we_d[k]   = rec_we_q[k-1];
      rec_dest_d[k] = rec_dest_q[k-1];
      rec_kind_d[k] = rec_kind_q[k-1];
    end

    // A fresh SP write or multi-cycle start reloads rather than accumulates.
    if (go && sp_wr_ex)             sp_pend_d = 3'(SP_LAT);
    else if (sp_pend_q != 3'd0)     sp_pend_d = sp_pend_q - 3'd1;
    else                            sp_pend_d = 3'd0;

    if (go && mc_start_ex && (mc_lat_ex != '0)) mc_cnt_d = mc_lat_ex;
    else if (mc_busy_w)                         mc_cnt_d = mc_cnt_q - CNT_W'(1);
    else                                        mc_cnt_d = '0;

    stall_cycles_d = stall_cycles_q;
    if (stall_w && (stall_cycles_q != 16'hFFFF)) stall_cycles_d = stall_cycles_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rec_vld_q      <= '0;
      sp_pend_q      <= 3'd0;
      mc_cnt_q       <= '0;
      stall_cycles_q <= 16'd0;
    end else begin
      rec_vld_q      <= rec_vld_d;
      sp_pend_q      <= sp_pend_d;
      mc_cnt_q       <= mc_cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  always_ff @(posedge clk) begin
    rec_we_q   <= rec_we_d;
    rec_dest_q <= rec_dest_d;
    rec_kind_q <= rec_kind_d;
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Randomised and directed bench for hazard_scoreboard_unit: a history-based
// reference model queues expected outputs, a monitor compares each cycle.
module tb_hazard_scoreboard_unit;

  localparam int FWD    = 2;
  localparam int SP_REG = 3;
  localparam int SP_LAT = 2;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst_n, issue_valid, flush, use_a, use_b, we_ex, sp_wr_ex, mc_start_ex;
  logic [1:0]       ra_ex, rb_ex, dest_ex, kind_ex;
  logic [CNT_W-1:0] mc_lat_ex;
  logic             stall, fwd_a_in, fwd_b_in, mc_busy;
  logic [1:0]       fwd_a_sel, fwd_b_sel;
  logic [15:0]      stall_cycles;

  hazard_scoreboard_unit #(
    .AW(2), .FWD_STAGES(FWD), .SP_REG(SP_REG), .SP_LAT(SP_LAT), .CNT_W(CNT_W), .SEL_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .flush(flush),
    .ra_ex(ra_ex), .rb_ex(rb_ex), .use_a(use_a), .use_b(use_b), .we_ex(we_ex),
    .dest_ex(dest_ex), .kind_ex(kind_ex), .sp_wr_ex(sp_wr_ex), .mc_start_ex(mc_start_ex),
    .mc_lat_ex(mc_lat_ex), .stall(stall), .fwd_a_sel(fwd_a_sel), .fwd_a_in(fwd_a_in),
    .fwd_b_sel(fwd_b_sel), .fwd_b_in(fwd_b_in), .mc_busy(mc_busy), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic       we;
    logic [1:0] dest;
    logic [1:0] kind;
  } ent_t;

  typedef struct packed {
    logic        stall;
    logic [1:0]  sa;
    logic        ia;
    logic [1:0]  sb;
    logic        ib;
    logic        busy;
    logic [15:0] sc;
  } exp_t;

  // Model state: issue history (youngest first), time of last SP write, end of MC busy window.
  ent_t hist[$];
  exp_t exp_q[$];
  int   cyc = 0;
  int   last_sp = -1000;
  int   mc_end = -1;
  int   count = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", int'(stall), int'(e.stall));
      chk("fwd_a_sel", int'(fwd_a_sel), int'(e.sa));
      chk("fwd_a_in", int'(fwd_a_in), int'(e.ia));
      chk("fwd_b_sel", int'(fwd_b_sel), int'(e.sb));
      chk("fwd_b_in", int'(fwd_b_in), int'(e.ib));
      chk("mc_busy", int'(mc_busy), int'(e.busy));
      chk("stall_cycles", int'(stall_cycles), int'(e.sc));
    end
  end

  task automatic src(input logic [1:0] a, input logic u, output logic lu,
                     output logic [1:0] sel, output logic in_s);
    lu = 1'b0; sel = 2'd0; in_s = 1'b0;
    if (u && issue_valid) begin
      for (int i = 0; i < hist.size(); i++) begin
        if (hist[i].v && hist[i].we && hist[i].dest == a) begin
          if (hist[i].kind == 2'd1 || hist[i].kind == 2'd2) begin
            if (i == 0) lu = 1'b1;
            else begin
              sel  = 2'(i + 1);
              in_s = (hist[i].kind == 2'd2);
            end
          end else begin
            sel = 2'(i + 1);
          end
          break;
        end
      end
    end
  endtask

  task automatic step();
    exp_t e;
    ent_t n;
    logic la, lb, spv, busy, st, go, ia, ib;
    logic [1:0] sa, sb;
    e  = '0;
    st = 1'b0;
    if (rst_n) begin
      src(ra_ex, use_a, la, sa, ia);
      src(rb_ex, use_b, lb, sb, ib);
      spv  = issue_valid && (cyc - last_sp <= SP_LAT) &&
             ((use_a && ra_ex == 2'(SP_REG)) || (use_b && rb_ex == 2'(SP_REG)));
      busy = (cyc <= mc_end);
      st   = !flush && (la || lb || spv || (busy && issue_valid));
      e    = {st, sa, ia, sb, ib, busy, 16'(count)};
    end else begin
      e.sc = 16'(count);
    end
    exp_q.push_back(e);
    if (!rst_n) begin
      hist.delete();
      last_sp = -1000;
      mc_end  = -1;
      count   = 0;
    end else begin
      go = issue_valid && !st && !flush;
      n  = {go, we_ex, dest_ex, kind_ex};
      hist.push_front(n);
      if (hist.size() > FWD) void'(hist.pop_back());
      if (go && sp_wr_ex) last_sp = cyc;
      if (go && mc_start_ex && mc_lat_ex != 0) mc_end = cyc + int'(mc_lat_ex);
      if (st && count < 65535) count++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rst_n = 1'b1; issue_valid = 1'b0; flush = 1'b0; use_a = 1'b0; use_b = 1'b0;
    we_ex = 1'b0; sp_wr_ex = 1'b0; mc_start_ex = 1'b0; ra_ex = 2'd0; rb_ex = 2'd0;
    dest_ex = 2'd0; kind_ex = 2'd0; mc_lat_ex = '0;
  endtask

  task automatic wr(input logic [1:0] d, input logic [1:0] k);
    clr(); issue_valid = 1'b1; we_ex = 1'b1; dest_ex = d; kind_ex = k;
  endtask

  task automatic do_reset();
    clr(); rst_n = 1'b0; step(); step(); clr();
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    // ALU writer then reader of R1
    wr(2'd1, 2'd0); step();
    clr(); issue_valid = 1; use_a = 1; ra_ex = 2'd1; step();
    // LOAD to R2, reader stalls once then forwards from stage 2
    wr(2'd2, 2'd1); step();
    clr(); issue_valid = 1; use_b = 1; rb_ex = 2'd2; step(); step();
    // INPUT to R0, unrelated op, reader
    wr(2'd0, 2'd2); step();
    clr(); issue_valid = 1; step();
    clr(); issue_valid = 1; use_a = 1; ra_ex = 2'd0; step();
    // INPUT to R0 shadowed by a younger ALU write
    wr(2'd0, 2'd2); step();
    wr(2'd0, 2'd0); step();
    clr(); issue_valid = 1; use_a = 1; ra_ex = 2'd0; step();
    // SP write then SP reader; then SP write then non-SP reader
    clr(); issue_valid = 1; sp_wr_ex = 1; step();
    clr(); issue_valid = 1; use_a = 1; ra_ex = 2'd3; step(); step(); step();
    clr(); issue_valid = 1; sp_wr_ex = 1; step();
    clr(); issue_valid = 1; use_a = 1; ra_ex = 2'd1; step();
    // Multi-cycle op with a reset landing in the middle
    clr(); issue_valid = 1; mc_start_ex = 1; mc_lat_ex = 8'd3; step();
    clr(); issue_valid = 1; step();
    rst_n = 1'b0; step();
    clr(); issue_valid = 1; step(); step();
    // Multi-cycle op run to completion, and zero-latency no-op
    clr(); issue_valid = 1; mc_start_ex = 1; mc_lat_ex = 8'd3; step();
    clr(); issue_valid = 1; step(); step(); step(); step();
    clr(); issue_valid = 1; mc_start_ex = 1; mc_lat_ex = 8'd0; step();
    clr(); issue_valid = 1; step();
    // Load-use with flush on the reader, which also writes R1
    wr(2'd2, 2'd1); step();
    wr(2'd1, 2'd0); use_a = 1; ra_ex = 2'd2; flush = 1; step();
    clr(); issue_valid = 1; use_a = 1; ra_ex = 2'd1; use_b = 1; rb_ex = 2'd2; step();

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      rst_n       = ($urandom_range(0, 79) != 0);
      issue_valid = ($urandom_range(0, 3) != 0);
      flush       = ($urandom_range(0, 7) == 0);
      ra_ex       = 2'($urandom_range(0, 3));
      rb_ex       = 2'($urandom_range(0, 3));
      use_a       = 1'($urandom_range(0, 1));
      use_b       = 1'($urandom_range(0, 1));
      we_ex       = ($urandom_range(0, 3) != 0);
      dest_ex     = 2'($urandom_range(0, 3));
      kind_ex     = 2'($urandom_range(0, 3));
      sp_wr_ex    = ($urandom_range(0, 7) == 0);
      mc_start_ex = ($urandom_range(0, 9) == 0);
      mc_lat_ex   = 8'($urandom_range(0, 4));
      step();
    end

    // Saturate the stall counter with back-to-back long multi-cycle ops
    do_reset();
    for (int r = 0; r < 260; r++) begin
      clr(); issue_valid = 1; mc_start_ex = 1; mc_lat_ex = 8'd255; step();
      clr(); issue_valid = 1;
      for (int j = 0; j < 255; j++) step();
    end
    clr(); step();

    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised, stateful hazard/forwarding unit for the EX stage of the pipelined processor.
- Tracks in-flight writers in an internal record pipeline, FWD_STAGES deep behind EX, instead of taking per-stage write info as ports.
- Generates per-source bypass selects, load/input-use stalls, stack-pointer-pending stalls and multi-cycle-op structural stalls.
- Keeps a saturating stall-cycle counter.

Parameters:
- AW, 2, register address width (2^AW architectural registers).
- FWD_STAGES, 2, number of stages behind EX that carry bypassable data (legal 2..4).
- SP_REG, 3, register index of the stack pointer.
- SP_LAT, 2, cycles after an SP-writing issue during which SP reads stall (legal 1..7).
- CNT_W, 3, width of multi-cycle latency field / counter.
- SEL_W, 2, width of forward select (must hold FWD_STAGES).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- issue_valid  in  1  EX holds a real instruction.
- flush  in  1  kill the EX instruction this cycle.
- ra_ex  in  AW  source A address.
- rb_ex  in  AW  source B address.
- use_a  in  1  instruction reads source A.
- use_b  in  1  instruction reads source B.
- we_ex  in  1  instruction writes the register file.
- dest_ex  in  AW  destination address, already resolved via SW1.
- kind_ex  in  2  data source: 0 = ALU, 1 = LOAD, 2 = INPUT port, 3 = reserved (treated as ALU).
- sp_wr_ex  in  1  instruction modifies SP.
- mc_start_ex  in  1  instruction starts a multi-cycle op.
- mc_lat_ex  in  CNT_W  busy cycles for that op.
- stall  out  1  hold EX and earlier stages.
- fwd_a_sel  out  SEL_W  0 = register file; k = bypass from stage k behind EX.
- fwd_a_in  out  1  selected bypass is input-port data.
- fwd_b_sel  out  SEL_W  as fwd_a_sel, for source B.
- fwd_b_in  out  1  as fwd_a_in, for source B.
- mc_busy  out  1  multi-cycle counter non-zero.
- stall_cycles  out  16  saturating count of stalled cycles.

Behaviour:
- Reset: while rst_n = 0 at a clock edge, all records are invalidated and sp_pend, mc_cnt and stall_cycles clear to 0. Combinational outputs are gated to 0 while rst_n = 0. A reset mid-multi-cycle-op or mid-SP-pending discards that state.
- Record k (1..FWD_STAGES) holds {valid, we, dest, kind}. Record 1 is the instruction one stage past EX.
- Issue is `go = issue_valid & ~stall & ~flush`.
- Each edge:
  - record 1 <= {go, we_ex, dest_ex, kind_ex}, i.e. a bubble when stalled or flushed;
  - record k <= record k-1 for k >= 2, always, so downstream drains during a stall.
- Source match, for A (B identical with rb_ex/use_b):
  - Applies only when use_a & issue_valid.
  - Scan k = 1 upward; the first record with valid & we & dest == ra_ex wins (youngest writer priority).
  - Winner kind ALU: fwd_a_sel = k, fwd_a_in = 0.
  - Winner kind LOAD or INPUT: if k = 1, raise stall and set fwd_a_sel = 0. Otherwise fwd_a_sel = k and fwd_a_in = (kind == INPUT).
  - No winner: fwd_a_sel = 0, fwd_a_in = 0.
- SP hazard:
  - go & sp_wr_ex loads sp_pend = SP_LAT. Otherwise sp_pend decrements toward 0.
  - Stall if sp_pend != 0 and a used source equals SP_REG.
  - A new SP write reloads sp_pend; pending time is not summed.
- Multi-cycle op:
  - go & mc_start_ex with mc_lat_ex != 0 loads mc_cnt = mc_lat_ex. Otherwise mc_cnt decrements toward 0.
  - mc_busy = (mc_cnt != 0).
  - Stall whenever mc_busy & issue_valid. The starting instruction itself is not stalled. mc_lat_ex = 0 is a no-op.
- flush forces stall = 0 and suppresses all SP/MC/record updates from the EX instruction. Records k >= 2 still advance.
- stall = OR of the load-use, SP and MC conditions, all combinational from inputs and state. Zero added latency.
- stall_cycles increments on each edge where stall = 1; it holds at 16'hFFFF.

Test Plan:
- ALU writes R1 (go), next cycle instruction reads ra=1 -> fwd_a_sel=1, fwd_a_in=0, stall=0.
- LOAD to R2, next reads rb=2 -> stall=1 for exactly 1 cycle, stall_cycles=1; following cycle fwd_b_sel=2, fwd_b_in=0.
- INPUT to R0, then unrelated op, then read ra=0 -> fwd_a_sel=2, fwd_a_in=1. Same setup with ALU also writing R0 in between -> fwd_a_sel=1 (youngest wins).
- sp_wr_ex issued (SP_LAT=2), next instruction reads ra=3 -> stall=1 for 2 cycles, then releases; an instruction reading ra=1 at the same point sees no stall.
- mc_start_ex with mc_lat_ex=3 -> mc_busy high 3 cycles; a valid instruction behind it stalls 3 cycles. Assert rst_n=0 during cycle 2 -> mc_busy=0, stall=0, stall_cycles=0 next cycle.
- LOAD-use stall cycle with flush=1 -> stall=0, record 1 bubble, no forward to the next instruction. Force 70000 stall cycles -> stall_cycles saturates at 65535.
